seq_divider_20bit: RTL and testbench

//  Multi-cycle signed 20-bit integer divider for the ODE step datapath.

---
 rtl/seq_divider_20bit.sv | 119 +++++++++++
 tb/tb_seq_divider_20bit.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_20bit.sv
// Multi-cycle signed divider: restoring shift-and-subtract, one quotient bit per clock.
// The start/busy/done handshake drives it; quo/rem/dz/v are held until the next result.
module seq_divider_20bit #(
  parameter int unsigned WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             dz,
  output logic             v
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t           state;
  logic [WIDTH:0]   r;
  logic [WIDTH:0]   dmag;
  logic [WIDTH-1:0] qm;
  logic [WIDTH-1:0] n_q;
  logic [CW-1:0]    cnt;
  logic             sn;
  logic             sq;
  logic             dz_p;
  logic             v_p;

  logic [WIDTH-1:0] nabs_c;
  logic [WIDTH-1:0] dabs_c;
  logic [WIDTH:0]   r_sh_c;
  logic [WIDTH+1:0] t_c;
  logic [WIDTH-1:0] quo_c;
  logic [WIDTH-1:0] rem_c;
  logic             ovf_c;

  // Magnitudes: the negation of -2^(WIDTH-1) reads correctly as an unsigned WIDTH-bit value.
  always_comb begin
    nabs_c = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
    dabs_c = divisor[WIDTH-1]  ? (~divisor + WIDTH'(1))  : divisor;
    r_sh_c = {r[WIDTH-1:0], qm[WIDTH-1]};
    t_c    = {1'b0, r_sh_c} - {1'b0, dmag};
    quo_c  = sq ? (~qm + WIDTH'(1)) : qm;
    rem_c  = sn ? (~r[WIDTH-1:0] + WIDTH'(1)) : r[WIDTH-1:0];
    ovf_c  = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      quo   <= '0;
      rem   <= '0;
      dz    <= 1'b0;
      v     <= 1'b0;
      r     <= '0;
      dmag  <= '0;
      qm    <= '0;
      n_q   <= '0;
      cnt   <= '0;
      sn    <= 1'b0;
      sq    <= 1'b0;
      dz_p  <= 1'b0;
      v_p   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            n_q   <= dividend;
            dmag  <= {1'b0, dabs_c};
            qm    <= nabs_c;
            r     <= '0;
            cnt   <= '0;
            sn    <= dividend[WIDTH-1];
            sq    <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            dz_p  <= (divisor == '0);
            v_p   <= ovf_c;
            busy  <= 1'b1;
            state <= (divisor == '0) ? SIGN : CALC;
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (!t_c[WIDTH+1]) begin
            r  <= t_c[WIDTH:0];
            qm <= {qm[WIDTH-2:0], 1'b1};
          end else begin
            r  <= r_sh_c;
            qm <= {qm[WIDTH-2:0], 1'b0};
          end
          if (cnt == CW'(WIDTH - 1)) state <= SIGN;
        end
        SIGN: begin
          quo   <= dz_p ? '0  : quo_c;
          rem   <= dz_p ? n_q : rem_c;
          dz    <= dz_p;
          v     <= dz_p ? 1'b0 : v_p;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider_20bit.sv
// Directed bench for seq_divider_20bit: expected results are queued at start
// and popped when done pulses, then compared with immediate assertions.
module tb_seq_divider_20bit;

  localparam int unsigned WIDTH = 20;

  typedef struct {
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic             dz;
    logic             v;
    int               lat;
    int               busy_cycles;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic             dz;
  logic             v;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  seq_divider_20bit #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quo      (quo),
    .rem      (rem),
    .dz       (dz),
    .v        (v)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Reference: int division truncates toward zero, remainder takes the dividend sign.
  function automatic exp_t model(input int n, input int d);
    exp_t e;
    int   q;
    int   r;
    if (d == 0) begin
      e.quo = '0;
      e.rem = WIDTH'(n);
      e.dz  = 1'b1;
      e.v   = 1'b0;
      e.lat = 1;
      e.busy_cycles = 1;
    end else begin
      q = n / d;
      r = n % d;
      e.quo = WIDTH'(q);
      e.rem = WIDTH'(r);
      e.dz  = 1'b0;
      e.v   = (n == -524288) && (d == -1);
      e.lat = WIDTH + 1;
      e.busy_cycles = WIDTH + 1;
    end
    return e;
  endfunction

  // Called just after a rising edge with the DUT idle; leaves it idle one cycle after done.
  task automatic run_op(input string tag, input int n, input int d, input bit pulse_mid);
    exp_t e;
    int   k;
    int   bc;
    bit   seen;
    sb.push_back(model(n, d));
    start    = 1'b1;
    dividend = WIDTH'(n);
    divisor  = WIDTH'(d);
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = WIDTH'($urandom);
    divisor  = WIDTH'($urandom);
    k = 0; bc = 0; seen = 1'b0;
    while (k < 60) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (busy) bc++;
      if (pulse_mid && k == 8) begin
        start = 1'b1; dividend = WIDTH'(9); divisor = WIDTH'(3);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    if (sb.size() == 0) begin
      check({tag, " sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check({tag, " latency"}, 32'(k), 32'(e.lat));
      check({tag, " busy_cycles"}, 32'(bc), 32'(e.busy_cycles));
      check({tag, " busy_at_done"}, 32'(busy), 32'd0);
      check({tag, " quo"}, 32'(quo), 32'(e.quo));
      check({tag, " rem"}, 32'(rem), 32'(e.rem));
      check({tag, " dz"}, 32'(dz), 32'(e.dz));
      check({tag, " v"}, 32'(v), 32'(e.v));
      // Start during the done cycle must be ignored.
      start = 1'b1; dividend = WIDTH'(77); divisor = WIDTH'(0);
      @(posedge clk); #1;
      start = 1'b0;
      check({tag, " done_one_cycle"}, 32'(done), 32'd0);
      check({tag, " start_in_done_ignored"}, 32'(busy), 32'd0);
      check({tag, " quo_held"}, 32'(quo), 32'(e.quo));
      check({tag, " rem_held"}, 32'(rem), 32'(e.rem));
    end
  endtask

  initial begin
    int n_done;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset quo", 32'(quo), 32'd0);
    check("reset rem", 32'(rem), 32'd0);
    check("reset dz", 32'(dz), 32'd0);
    check("reset v", 32'(v), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("p100_p7", 100, 7, 1'b0);
    run_op("n100_p7", -100, 7, 1'b0);
    run_op("p100_n7", 100, -7, 1'b0);
    run_op("n100_n7", -100, -7, 1'b0);
    run_op("div0_p5", 5, 0, 1'b0);
    run_op("div0_n7", -7, 0, 1'b0);
    run_op("min_n1", -524288, -1, 1'b0);
    run_op("max_p1", 524287, 1, 1'b0);
    run_op("min_p1", -524288, 1, 1'b0);
    run_op("small_n3_p100", -3, 100, 1'b0);
    run_op("max_min", 524287, -524288, 1'b0);
    run_op("mid_start", 100, 7, 1'b1);
    run_op("b2b_9_3", 9, 3, 1'b0);

    // Reset during CALC: abort with outputs cleared and no done pulse.
    start = 1'b1; dividend = WIDTH'(1000); divisor = WIDTH'(3);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("abort busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort quo", 32'(quo), 32'd0);
    check("abort rem", 32'(rem), 32'd0);
    check("abort dz", 32'(dz), 32'd0);
    check("abort v", 32'(v), 32'd0);
    rst_n = 1'b1;
    n_done = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done || busy) n_done++;
    end
    check("abort no_done", 32'(n_done), 32'd0);
    run_op("post_abort_3_5", 3, 5, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
